// File: rtl/catch_referee.sv
// catch_referee: game-flow controller for the two-glove catch game
module catch_referee #(
  parameter int TICK_DIV         = 210937,
  parameter int LOCKOUT_TICKS    = 32,
  parameter int MAX_FLIGHT_TICKS = 640,
  parameter int DROP_WAIT_TICKS  = 128,
  parameter int FLOOR_Y          = 55
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  ball_state,
  input  logic [15:0] ball_y,
  output logic        can_catch1,
  output logic        can_catch2,
  output logic        ball_reset,
  output logic [2:0]  phase,
  output logic [1:0]  thrower,
  output logic [7:0]  score1,
  output logic [7:0]  score2,
  output logic [7:0]  drops
);
  typedef enum logic [2:0] {
    SERVE   = 3'd0,
    HELD1   = 3'd1,
    HELD2   = 3'd2,
    FLIGHT  = 3'd3,
    DROPPED = 3'd4
  } phase_e;

  localparam logic [17:0] TICK_RELOAD = 18'(TICK_DIV);
  localparam logic [9:0]  LOCK_T      = 10'(LOCKOUT_TICKS);
  localparam logic [9:0]  MAX_T       = 10'(MAX_FLIGHT_TICKS);
  localparam logic [9:0]  WAIT_T      = 10'(DROP_WAIT_TICKS);
  localparam logic [15:0] FLOOR       = 16'(FLOOR_Y);

  phase_e      phase_q, phase_d;
  logic [17:0] tick_cnt_q, tick_cnt_d;
  logic [9:0]  timer_q, timer_d;
  logic [1:0]  thrower_q, thrower_d;
  logic [7:0]  score1_q, score1_d, score2_q, score2_d, drops_q, drops_d;
  logic        ball_reset_q, ball_reset_d;
  logic        can_catch1_q, can_catch1_d, can_catch2_q, can_catch2_d;
  logic        tick;
  logic        landed;

  assign tick   = tick_cnt_q == '0;
  assign landed = ball_state == 2'd0 && ball_y < FLOOR;

  // Tick divider reload and phase timer: cleared on any phase change, saturating tick count otherwise
  always_comb begin
    tick_cnt_d = tick ? TICK_RELOAD : tick_cnt_q - 18'd1;
    timer_d    = (phase_d != phase_q) ? '0 :
                 (tick && timer_q != '1) ? timer_q + 10'd1 : timer_q;
  end

  // Phase sequencing and score keeping; ball_state 3 falls through as "no change"
  always_comb begin
    phase_d   = phase_q;
    thrower_d = thrower_q;
    score1_d  = score1_q;
    score2_d  = score2_q;
    drops_d   = drops_q;
    case (phase_q)
      SERVE: begin
        if (ball_state == 2'd1) phase_d = HELD1;
        else if (ball_state == 2'd2) phase_d = HELD2;
      end
      HELD1: begin
        if (ball_state == 2'd0) begin
          phase_d   = FLIGHT;
          thrower_d = 2'd1;
        end else if (ball_state == 2'd2) phase_d = HELD2;
      end
      HELD2: begin
        if (ball_state == 2'd0) begin
          phase_d   = FLIGHT;
          thrower_d = 2'd2;
        end else if (ball_state == 2'd1) phase_d = HELD1;
      end
      FLIGHT: begin
        if (ball_state == 2'd1) begin
          phase_d  = HELD1;
          score1_d = (thrower_q != 2'd1 && score1_q != 8'hff) ? score1_q + 8'd1 : score1_q;
        end else if (ball_state == 2'd2) begin
          phase_d  = HELD2;
          score2_d = (thrower_q != 2'd2 && score2_q != 8'hff) ? score2_q + 8'd1 : score2_q;
        end else if (landed || timer_q >= MAX_T) begin
          phase_d = DROPPED;
          drops_d = (drops_q != 8'hff) ? drops_q + 8'd1 : drops_q;
        end
      end
      DROPPED: begin
        if (timer_q >= WAIT_T) phase_d = SERVE;
      end
      default: phase_d = SERVE;
    endcase
  end

  // Output flops are fed from next-state values so they line up with the registered phase
  always_comb begin
    ball_reset_d = phase_d == SERVE;
    can_catch1_d = phase_d == FLIGHT && (thrower_d != 2'd1 || timer_d >= LOCK_T);
    can_catch2_d = phase_d == FLIGHT && (thrower_d != 2'd2 || timer_d >= LOCK_T);
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q      <= SERVE;
      tick_cnt_q   <= TICK_RELOAD;
      timer_q      <= '0;
      thrower_q    <= '0;
      score1_q     <= '0;
      score2_q     <= '0;
      drops_q      <= '0;
      ball_reset_q <= 1'b1;
      can_catch1_q <= 1'b0;
      can_catch2_q <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      tick_cnt_q   <= tick_cnt_d;
      timer_q      <= timer_d;
      thrower_q    <= thrower_d;
      score1_q     <= score1_d;
      score2_q     <= score2_d;
      drops_q      <= drops_d;
      ball_reset_q <= ball_reset_d;
      can_catch1_q <= can_catch1_d;
      can_catch2_q <= can_catch2_d;
    end
  end

  assign phase      = phase_q;
  assign thrower    = thrower_q;
  assign score1     = score1_q;
  assign score2     = score2_q;
  assign drops      = drops_q;
  assign ball_reset = ball_reset_q;
  assign can_catch1 = can_catch1_q;
  assign can_catch2 = can_catch2_q;
endmodule

// File: tb/tb_catch_referee.sv
// tb_catch_referee: directed self-checking bench for catch_referee
module tb_catch_referee;
  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [1:0]  ball_state = 2'd0;
  logic [15:0] ball_y = 16'd1000;
  logic        can_catch1, can_catch2, ball_reset;
  logic [2:0]  phase;
  logic [1:0]  thrower;
  logic [7:0]  score1, score2, drops;
  logic        s_reset_n = 1'b1;
  logic [1:0]  s_state = 2'd0;
  logic [15:0] s_y = 16'd10;
  logic        s_cc1, s_cc2, s_ball_reset;
  logic [2:0]  s_phase;
  logic [1:0]  s_thrower;
  logic [7:0]  s_score1, s_score2, s_drops;
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  catch_referee #(.TICK_DIV(3)) dut (
    .clk(clk), .reset_n(reset_n), .ball_state(ball_state), .ball_y(ball_y),
    .can_catch1(can_catch1), .can_catch2(can_catch2), .ball_reset(ball_reset),
    .phase(phase), .thrower(thrower), .score1(score1), .score2(score2), .drops(drops)
  );

  catch_referee #(.TICK_DIV(3), .DROP_WAIT_TICKS(2)) u_sat (
    .clk(clk), .reset_n(s_reset_n), .ball_state(s_state), .ball_y(s_y),
    .can_catch1(s_cc1), .can_catch2(s_cc2), .ball_reset(s_ball_reset),
    .phase(s_phase), .thrower(s_thrower), .score1(s_score1), .score2(s_score2), .drops(s_drops)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sat_wait(input logic [2:0] p, input int limit);
    for (int i = 0; i < limit && s_phase != p; i++) step(1);
    if (s_phase != p) chk("sat_wait", int'(s_phase), int'(p));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_phase"}, phase, 0);
    chk({tag, "_ball_reset"}, ball_reset, 1);
    chk({tag, "_cc1"}, can_catch1, 0);
    chk({tag, "_cc2"}, can_catch2, 0);
    chk({tag, "_thrower"}, thrower, 0);
    chk({tag, "_score1"}, score1, 0);
    chk({tag, "_score2"}, score2, 0);
    chk({tag, "_drops"}, drops, 0);
  endtask

  initial begin
    #2 reset_n = 1'b0;
    s_reset_n = 1'b0;
    #10 chk_reset_vals("rst");
    @(posedge clk); #1;
    reset_n = 1'b1;
    s_reset_n = 1'b1;
    step(3);
    chk("serve_phase", phase, 0);
    chk("serve_ball_reset", ball_reset, 1);
    ball_state = 2'd1; step(1);
    chk("held1_phase", phase, 1);
    chk("held1_ball_reset", ball_reset, 0);
    chk("held1_cc1", can_catch1, 0);
    chk("held1_cc2", can_catch2, 0);
    ball_state = 2'd0; step(1);
    chk("pass_phase", phase, 3);
    chk("pass_thrower", thrower, 1);
    chk("pass_cc1", can_catch1, 0);
    chk("pass_cc2", can_catch2, 1);
    step(119);
    chk("lockout_30_cc1", can_catch1, 0);
    step(10);
    chk("lockout_32_cc1", can_catch1, 1);
    ball_state = 2'd2; step(1);
    chk("catch2_phase", phase, 2);
    chk("catch2_score2", score2, 1);
    chk("catch2_score1", score1, 0);
    chk("catch2_cc2", can_catch2, 0);
    ball_state = 2'd0; step(1);
    chk("self_phase", phase, 3);
    chk("self_thrower", thrower, 2);
    chk("self_cc1", can_catch1, 1);
    chk("self_cc2", can_catch2, 0);
    step(160);
    ball_state = 2'd2; step(1);
    chk("self_held_phase", phase, 2);
    chk("self_score1", score1, 0);
    chk("self_score2", score2, 1);
    ball_state = 2'd0; step(1);
    ball_y = 16'd55; step(2);
    chk("floor55_phase", phase, 3);
    ball_y = 16'd54; step(1);
    chk("drop_phase", phase, 4);
    chk("drop_drops", drops, 1);
    chk("drop_cc2", can_catch2, 0);
    ball_state = 2'd1; step(4);
    chk("drop_ignore_phase", phase, 4);
    ball_state = 2'd0; step(503);
    chk("drop_wait_127", phase, 4);
    step(8);
    chk("reserve_phase", phase, 0);
    chk("reserve_ball_reset", ball_reset, 1);
    ball_y = 16'd3000;
    ball_state = 2'd2; step(1);
    ball_state = 2'd0; step(1);
    chk("stuck_phase", phase, 3);
    step(2555);
    chk("stuck_639", phase, 3);
    step(8);
    chk("stuck_drop_phase", phase, 4);
    chk("stuck_drops", drops, 2);
    step(520);
    chk("stuck_reserve", phase, 0);
    ball_state = 2'd2; step(1);
    ball_state = 2'd0; step(1);
    chk("simul_flight", phase, 3);
    ball_y = 16'd10;
    ball_state = 2'd1; step(1);
    chk("simul_phase", phase, 1);
    chk("simul_score1", score1, 1);
    chk("simul_drops", drops, 2);
    ball_y = 16'd3000;
    ball_state = 2'd3; step(2);
    chk("inv_held", phase, 1);
    ball_state = 2'd0; step(1);
    ball_state = 2'd3; step(2);
    chk("inv_flight", phase, 3);
    #2 reset_n = 1'b0;
    #1 chk_reset_vals("async");
    step(2);
    reset_n = 1'b1;
    for (int k = 0; k < 300; k++) begin
      s_state = 2'd1;
      sat_wait(3'd1, 10);
      s_state = 2'd0;
      sat_wait(3'd4, 10);
      sat_wait(3'd0, 40);
      if (k == 254) chk("sat_254", s_drops, 255);
    end
    chk("sat_drops", s_drops, 255);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
